asrm_mem_bridge: RTL
====================

Name: asrm_mem_bridge

Overview:
- Sits directly downstream of the CPU address stage, between its single-word RAM port (addr, data_out, write_en, data_in) and a shared memory bus with a req/ack handshake and variable latency.
- Turns each new CPU access into one bus transaction and stalls the CPU until it completes.
- Holds the last completed result so repeated identical accesses cost no bus cycles.
- Aborts with a sticky error on bus timeout.

Parameters:
- wordsize, 16, width of address and data words.
- timeout, 255, maximum cycles bus_req stays high without bus_ack before abort (1..2^16-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_addr  in  wordsize  address from the address stage.
- cpu_wdata  in  wordsize  write data from the address stage.
- cpu_we  in  1  write enable from the address stage.
- cpu_flush  in  1  clears the held-result valid flag; the next cycle re-issues the access.
- cpu_rdata  out  wordsize  result of the last completed access; feeds the address stage's data_in.
- cpu_stall  out  1  high while the current CPU access is not yet complete.
- bus_addr  out  wordsize  registered transaction address.
- bus_wdata  out  wordsize  registered transaction write data.
- bus_we  out  1  registered transaction write flag.
- bus_req  out  1  transaction request, registered.
- bus_ack  in  1  transaction complete; bus_rdata valid in the same cycle.
- bus_rdata  in  wordsize  read data from the bus.
- bus_error  out  1  sticky timeout flag.

Behaviour:
- Internal state:
  - key registers last_addr, last_wdata, last_we, plus last_valid.
  - FSM states IDLE and REQ.
  - timeout counter.
- Definitions:
  - match = last_valid & cpu_addr==last_addr & cpu_we==last_we & (!cpu_we | cpu_wdata==last_wdata).
  - need = !match.
- cpu_stall is combinational: (state==REQ) | (state==IDLE & need). Low exactly when the IDLE state's key matches the inputs.
- IDLE:
  - bus_req=0.
  - If need at an edge: latch cpu_addr/cpu_wdata/cpu_we into bus_addr/bus_wdata/bus_we, set bus_req=1, clear the counter, go to REQ.
  - bus_ack in IDLE is ignored.
- REQ:
  - bus_addr/bus_wdata/bus_we and bus_req are held stable; CPU input changes are ignored.
  - On an edge with bus_ack=1:
    - bus_req=0.
    - Read: cpu_rdata<=bus_rdata. Write: cpu_rdata<=bus_wdata (write-through echo).
    - Key regs<=bus regs, last_valid<=1, go to IDLE.
  - Else the counter increments. When counter==timeout-1 and still no ack:
    - bus_req=0, cpu_rdata<=0, bus_error<=1.
    - Key regs<=bus regs, last_valid<=1, go to IDLE.
- Latency:
  - Access detected at edge N; bus_req high from N+1.
  - Ack sampled at edge M≥N+1; cpu_rdata updated and cpu_stall low after M, with unchanged inputs.
  - Minimum 2 stall cycles.
  - Identical following access: 0 stall cycles.
- cpu_flush:
  - In IDLE: last_valid<=0, so need is asserted next cycle.
  - In REQ: the flush is recorded and applied right after completion (last_valid forced 0), causing one re-issue.
  - Flush and completion on the same edge: the flush wins (last_valid=0).
- A write with the same addr and data as the last completed write is skipped (idempotent).
- bus_error clears only on reset.
- Reset (reset==0 at an edge, any state including mid-REQ):
  - state=IDLE, bus_req=0, bus_addr/bus_wdata/bus_we=0, cpu_rdata=0, last_valid=0, counter=0, bus_error=0, pending flush=0.
  - A late ack after reset is ignored.
- cpu_stall is 1 during and right after reset, because last_valid=0.
- The counter is wide enough for timeout; no wrap occurs before abort.

Test Plan:
- Read: reset, cpu_addr=0x0010, cpu_we=0, bus acks 3 cycles after bus_req with rdata 0xBEEF -> bus_addr=0x0010, bus_req high exactly 3 cycles, cpu_rdata=0xBEEF, stall drops the following cycle.
- Repeat/skip: hold cpu_addr=0x0010 for 5 more cycles -> no further bus_req, cpu_stall=0. Then write 0x1234 to 0x0010 twice in a row -> exactly one bus transaction with bus_we=1.
- Immediate ack: bus_ack held high permanently, address changes every cycle 0x0..0x5 -> every access takes 2 cycles, bus_req pulses 1 cycle each.
- Input change mid-REQ: change cpu_addr 0x0020->0x0030 while REQ for 0x0020 -> bus_addr stays 0x0020 until ack, then a new transaction for 0x0030.
- Timeout: timeout=8, never ack -> bus_req high 8 cycles then low, cpu_rdata=0, bus_error=1 and stays 1. Reset -> bus_error=0.
- Reset mid-REQ plus flush: pulse reset during REQ -> bus_req=0 next cycle, late ack ignored. After normal completion at 0x0040, assert cpu_flush -> same address re-issued once.

Source files
------------

// File: rtl/asrm_mem_bridge_if.sv
// Shared memory bus: the bridge drives the request side (master), the memory
// system answers with ack/rdata (slave).
interface asrm_mem_bridge_if #(
  parameter int wordsize = 16
);
  logic [wordsize-1:0] bus_addr;
  logic [wordsize-1:0] bus_wdata;
  logic                bus_we;
  logic                bus_req;
  logic                bus_ack;
  logic [wordsize-1:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_req,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_req,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/asrm_mem_bridge.sv
// CPU single-word RAM port to req/ack memory bus bridge: one bus transaction per
// new access, last result held so repeated accesses cost nothing, sticky timeout.
module asrm_mem_bridge #(
  parameter int wordsize = 16,
  parameter int timeout  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  input  logic                cpu_we,
  input  logic                cpu_flush,
  output logic [wordsize-1:0] cpu_rdata,
  output logic                cpu_stall,
  asrm_mem_bridge_if.master   bus,
  output logic                bus_error
);

  // Counter only has to reach timeout-1, the abort point.
  localparam int CNT_W = (timeout > 1) ? $clog2(timeout) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [wordsize-1:0] last_addr;
  logic [wordsize-1:0] last_wdata;
  logic                last_we;
  logic                last_valid;
  logic                flush_pend;
  logic                match;
  logic                need;

  // Write data only matters to the key when the access is a write.
  always_comb begin
    match = last_valid && (cpu_addr == last_addr) && (cpu_we == last_we) &&
            (!cpu_we || (cpu_wdata == last_wdata));
    need      = !match;
    cpu_stall = (state == REQ) || ((state == IDLE) && need);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_we    <= 1'b0;
      cpu_rdata     <= '0;
      bus_error     <= 1'b0;
      last_addr     <= '0;
      last_wdata    <= '0;
      last_we       <= 1'b0;
      last_valid    <= 1'b0;
      flush_pend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_flush) last_valid <= 1'b0;
          if (need) begin
            bus.bus_addr  <= cpu_addr;
            bus.bus_wdata <= cpu_wdata;
            bus.bus_we    <= cpu_we;
            bus.bus_req   <= 1'b1;
            cnt           <= '0;
            state         <= REQ;
          end
        end
        default: begin
          if (cpu_flush) flush_pend <= 1'b1;
          if (bus.bus_ack || (cnt == CNT_LAST)) begin
            // Ack on the final allowed cycle still counts as a normal completion.
            bus.bus_req <= 1'b0;
            if (bus.bus_ack)
              cpu_rdata <= bus.bus_we ? bus.bus_wdata : bus.bus_rdata;
            else begin
              cpu_rdata <= '0;
              bus_error <= 1'b1;
            end
            last_addr  <= bus.bus_addr;
            last_wdata <= bus.bus_wdata;
            last_we    <= bus.bus_we;
            last_valid <= !(flush_pend || cpu_flush);
            flush_pend <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
